// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
// Request and response bundle for the shared ALU arbiter.
//
// Handshake: a requester raises reqN_valid with reqN_op/a/b and holds all four
// stable until it sees reqN_ready high in the same cycle. A transfer happens
// on a rising edge where valid && ready are both high. Valid must never be
// made to depend on ready. The response side has no ready. rsp_valid is a
// one-cycle pulse that the owner named by rsp_id must take.
//
// Signals (master = requester side, slave = arbiter side):
//   reqN_valid  m->s  operation pending on requester N
//   reqN_ready  s->m  requester N accepted this cycle
//   reqN_op     m->s  00 AND, 01 OR, 10 ADD, 11 MUL
//   reqN_a/b    m->s  two's-complement operands, WIDTH bits
//   rsp_valid   s->m  result present (single-cycle pulse)
//   rsp_id      s->m  requester owning the result
//   rsp_result  s->m  2*WIDTH-bit result
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [1:0]           req0_op;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [1:0]           req1_op;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;

    logic                 rsp_valid;
    logic                 rsp_id;
    logic [2*WIDTH-1:0]   rsp_result;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one signed WIDTH-bit ALU between two requesters with round-robin
// arbitration. AND/OR/ADD answer one cycle after accept. MUL is an iterative
// shift-add on operand magnitudes that holds the ALU for WIDTH cycles plus a
// finishing cycle that applies the sign.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   arb_if   request/response bundle (slave side)
//   state_o  current FSM state (0 IDLE, 1 MUL, 2 FIN) for observation
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_share_arbiter_if.slave        arb_if,
    output logic [1:0]                state_o
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Id of the requester granted most recently; resets to 1 so req0 wins
    // the first tie.
    logic              last_q;

    logic              grant_vld;
    logic              grant_id;
    logic              accept;

    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [RW-1:0]     single_res;

    logic [RW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [RW-1:0]     acc_q;
    logic              sign_q;
    logic [CW-1:0]     cnt_q;
    logic              owner_q;

    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [RW-1:0]     rsp_result_q;

    // ---------------------------------------------------------------------
    // Arbitration: purely a function of valids and the last-grant pointer.
    // ---------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (arb_if.req0_valid && arb_if.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_q;
        end else if (arb_if.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (arb_if.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 1: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 2: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (sel_op == OP_MUL)) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM process 3: outputs (ready/accept only exist in IDLE)
    // ---------------------------------------------------------------------
    always_comb begin
        arb_if.req0_ready = 1'b0;
        arb_if.req1_ready = 1'b0;
        accept            = 1'b0;
        if (state_q == ST_IDLE) begin
            accept            = grant_vld;
            arb_if.req0_ready = grant_vld && !grant_id;
            arb_if.req1_ready = grant_vld &&  grant_id;
        end
    end

    // ---------------------------------------------------------------------
    // Operand selection and single-cycle results
    // ---------------------------------------------------------------------
    always_comb begin
        sel_op = grant_id ? arb_if.req1_op : arb_if.req0_op;
        sel_a  = grant_id ? arb_if.req1_a  : arb_if.req0_a;
        sel_b  = grant_id ? arb_if.req1_b  : arb_if.req0_b;
    end

    // Magnitudes as unsigned WIDTH-bit values; the most negative operand maps
    // onto 2^(WIDTH-1), which still fits unsigned.
    assign abs_a = sel_a[WIDTH-1] ? (~sel_a + WIDTH'(1)) : sel_a;
    assign abs_b = sel_b[WIDTH-1] ? (~sel_b + WIDTH'(1)) : sel_b;

    always_comb begin
        single_res = '0;
        case (sel_op)
            OP_AND:  single_res = {{WIDTH{1'b0}}, sel_a & sel_b};
            OP_OR:   single_res = {{WIDTH{1'b0}}, sel_a | sel_b};
            OP_ADD:  single_res = {{WIDTH{sel_a[WIDTH-1]}}, sel_a}
                                + {{WIDTH{sel_b[WIDTH-1]}}, sel_b};
            default: single_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath, pointer and response registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            sign_q       <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        last_q  <= grant_id;
                        owner_q <= grant_id;
                        if (sel_op == OP_MUL) begin
                            mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                            mplier_q <= abs_b;
                            acc_q    <= '0;
                            sign_q   <= sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
                            cnt_q    <= '0;
                        end else begin
                            rsp_valid_q  <= 1'b1;
                            rsp_id_q     <= grant_id;
                            rsp_result_q <= single_res;
                        end
                    end
                end
                ST_MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                end
                ST_FIN: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= owner_q;
                    rsp_result_q <= sign_q ? (~acc_q + RW'(1)) : acc_q;
                end
                default: ;
            endcase
        end
    end

    assign arb_if.rsp_valid  = rsp_valid_q;
    assign arb_if.rsp_id     = rsp_id_q;
    assign arb_if.rsp_result = rsp_result_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed and random stimulus for alu_share_arbiter. Requesters are modelled
// as queues of pending operations; a transaction-level model predicts grants,
// results and response cycles from the arbitration and latency rules.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int W = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W)) bus ();

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_if  (bus),
        .state_o (state_o)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Pending operations per requester: {op[1:0], a[7:0], b[7:0]}
    logic [17:0] q0[$];
    logic [17:0] q1[$];

    // Scoreboard: expected {id, result} and the cycle it must appear in
    logic [16:0] exp_q[$];
    int          due_q[$];

    logic        ptr;
    int          blocked;
    logic [15:0] last_res;
    logic        last_id;

    int          acc_id_log[$];
    int          acc_cyc_log[$];
    int          rsp_id_log[$];
    int          rsp_cyc_log[$];
    logic [15:0] rsp_res_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_result(input logic [1:0] op,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00:   r = {24'h0, a & b};
            2'b01:   r = {24'h0, a | b};
            2'b10:   r = sa + sb;
            default: r = sa * sb;
        endcase
        return r[15:0];
    endfunction

    task automatic clear_logs();
        acc_id_log.delete();
        acc_cyc_log.delete();
        rsp_id_log.delete();
        rsp_cyc_log.delete();
        rsp_res_log.delete();
    endtask

    task automatic push0(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        q0.push_back({op, a, b});
    endtask

    task automatic push1(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        q1.push_back({op, a, b});
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step();
        logic [17:0] h0;
        logic [17:0] h1;
        logic [17:0] h;
        logic [15:0] r;
        logic [16:0] e;
        bit          v0;
        bit          v1;
        int          g;
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        h0 = v0 ? q0[0] : 18'($urandom);
        h1 = v1 ? q1[0] : 18'($urandom);
        bus.req0_valid = v0;
        bus.req0_op    = h0[17:16];
        bus.req0_a     = h0[15:8];
        bus.req0_b     = h0[7:0];
        bus.req1_valid = v1;
        bus.req1_op    = h1[17:16];
        bus.req1_a     = h1[15:8];
        bus.req1_b     = h1[7:0];
        #1;
        g = -1;
        if (blocked == 0) begin
            if (v0 && v1)  g = ptr ? 0 : 1;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        chk("req0_ready", bus.req0_ready, g == 0);
        chk("req1_ready", bus.req1_ready, g == 1);
        if (g >= 0) begin
            h = (g == 0) ? h0 : h1;
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            r = ref_result(h[17:16], h[15:8], h[7:0]);
            exp_q.push_back({g[0], r});
            due_q.push_back(cyc + ((h[17:16] == 2'b11) ? 10 : 1));
            if (h[17:16] == 2'b11) blocked = 10;
            ptr = g[0];
            acc_id_log.push_back(g);
            acc_cyc_log.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (blocked > 0) blocked--;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            chk("rsp_valid", bus.rsp_valid, 1'b1);
            chk("rsp_id", bus.rsp_id, e[16]);
            chk("rsp_result", bus.rsp_result, e[15:0]);
            rsp_id_log.push_back(int'(bus.rsp_id));
            rsp_cyc_log.push_back(cyc);
            rsp_res_log.push_back(bus.rsp_result);
            last_id  = e[16];
            last_res = e[15:0];
        end else begin
            chk("rsp_idle", bus.rsp_valid, 1'b0);
            chk("rsp_id_hold", bus.rsp_id, last_id);
            chk("rsp_result_hold", bus.rsp_result, last_res);
        end
    endtask

    task automatic run(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || due_q.size() > 0) && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, n < max_cyc, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 16'h0);
        chk("rst_state", state_o, 2'd0);
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_req1_ready", bus.req1_ready, 1'b0);
        q0.delete();
        q1.delete();
        exp_q.delete();
        due_q.delete();
        ptr      = 1'b1;
        blocked  = 0;
        last_res = '0;
        last_id  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.req0_valid = 1'b0;
        bus.req0_op    = '0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;

        do_reset();

        // AND straight after reset
        clear_logs();
        c0 = cyc;
        push0(2'b00, 8'hF0, 8'h3C);
        run(20, "t1_timeout");
        chk("t1_acc_cycle", acc_cyc_log[0] - c0, 0);
        chk("t1_rsp_count", rsp_cyc_log.size(), 1);
        chk("t1_rsp_cycle", rsp_cyc_log[0] - c0, 1);
        chk("t1_rsp_id", rsp_id_log[0], 0);
        chk("t1_rsp_result", rsp_res_log[0], 16'h0030);

        // Tie after reset: req0 first, full throughput
        do_reset();
        clear_logs();
        c0 = cyc;
        push0(2'b10, 8'h7F, 8'h01);
        push1(2'b10, 8'h80, 8'hFF);
        run(20, "t2_timeout");
        chk("t2_acc0_id", acc_id_log[0], 0);
        chk("t2_acc1_id", acc_id_log[1], 1);
        chk("t2_acc1_cycle", acc_cyc_log[1] - c0, 1);
        chk("t2_rsp0_cycle", rsp_cyc_log[0] - c0, 1);
        chk("t2_rsp0_result", rsp_res_log[0], 16'h0080);
        chk("t2_rsp1_cycle", rsp_cyc_log[1] - c0, 2);
        chk("t2_rsp1_result", rsp_res_log[1], 16'hFF7F);

        // req1 MUL holds the ALU while req0 waits with OR
        clear_logs();
        c0 = cyc;
        push1(2'b11, 8'h80, 8'h80);
        step();
        push0(2'b01, 8'hA5, 8'h5A);
        run(40, "t3_timeout");
        chk("t3_mul_rsp_cycle", rsp_cyc_log[0] - c0, 10);
        chk("t3_mul_rsp_id", rsp_id_log[0], 1);
        chk("t3_mul_result", rsp_res_log[0], 16'h4000);
        chk("t3_or_acc_cycle", acc_cyc_log[1] - c0, 10);
        chk("t3_or_rsp_cycle", rsp_cyc_log[1] - c0, 11);
        chk("t3_or_result", rsp_res_log[1], 16'h00FF);

        // Signed MUL corners
        clear_logs();
        push0(2'b11, 8'hFD, 8'h05);
        push1(2'b11, 8'h7F, 8'hFF);
        push0(2'b11, 8'h00, 8'h80);
        run(80, "t4_timeout");
        chk("t4_rsp_count", rsp_res_log.size(), 3);
        chk("t4_mul_7f_ff", rsp_res_log[0], 16'hFF81);
        chk("t4_mul_fd_05", rsp_res_log[1], 16'hFFF1);
        chk("t4_mul_00_80", rsp_res_log[2], 16'h0000);

        // Reset in cycle 4 of a MUL aborts it
        push1(2'b10, 8'h40, 8'h33);
        run(20, "t5_pre_timeout");
        c0 = cyc;
        push0(2'b11, 8'h7F, 8'h7F);
        step();
        idle(3);
        chk("t5_in_mul_cycle", cyc - c0, 4);
        do_reset();
        clear_logs();
        push0(2'b00, 8'hFF, 8'h0F);
        push1(2'b00, 8'hFF, 8'hF0);
        run(20, "t5_post_timeout");
        chk("t5_first_grant", acc_id_log[0], 0);
        chk("t5_second_grant", acc_id_log[1], 1);
        idle(12);

        // Both continuously valid: strict alternation, one accept per cycle
        clear_logs();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            push0(2'b00, 8'($urandom), 8'($urandom));
            push1(2'b00, 8'($urandom), 8'($urandom));
        end
        run(30, "t6_timeout");
        for (int i = 0; i < 8; i++) begin
            chk("t6_grant_id", acc_id_log[i], i % 2);
            chk("t6_grant_cycle", acc_cyc_log[i] - c0, i);
            chk("t6_rsp_id", rsp_id_log[i], i % 2);
            chk("t6_rsp_cycle", rsp_cyc_log[i] - c0, i + 1);
        end

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1)
                push0(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0)
                push1(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            step();
        end
        run(4000, "random_drain_timeout");
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
